// File: rtl/disease_pkg.sv
// Shared definitions for the epidemic agent array and its monitors.
//   SUS/INF      : per-agent currState encoding
//   count_width  : bits needed to hold an infected count of 0..n
//   record_width : width of a {stepIdx, infCount} record
//   mon_state_e  : infection_monitor run-control states
//   record_t     : record layout for the default configuration (16-bit step, 10 agents)
package disease_pkg;

  localparam logic SUS = 1'b0;
  localparam logic INF = 1'b1;

  function automatic int unsigned count_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int unsigned record_width(input int unsigned step_w, input int unsigned n);
    return step_w + count_width(n);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_e;

  localparam int unsigned DEF_STEP_W = 16;
  localparam int unsigned DEF_CW     = 4;

  typedef struct packed {
    logic [DEF_STEP_W-1:0] step;
    logic [DEF_CW-1:0]     count;
  } record_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered write (data visible one cycle after push).
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : empties the FIFO; wins over push/pop
//   push_i/wdata_i : write request; accepted when not full or when popping same cycle
//   pop_i        : read request; ignored when empty
//   rdata_o      : head entry, '0 while empty
//   full_o, empty_o : occupancy status
// DEPTH must be a power of two, >= 2.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/infection_monitor.sv
// Samples the agent array once per simulation step, counts infected agents,
// tracks the epidemic peak, detects extinction and streams {stepIdx, infCount}
// records to the host through a FIFO with a valid/ready handshake.
//   clk, rst     : clock, synchronous active-high reset
//   agentStates  : currState per agent (INF = 1)
//   loadState    : agent array being initialised; aborts to IDLE and flushes FIFO
//   start        : begin a run from IDLE/DONE (loadState low)
//   sampleData/sampleValid/sampleReady : record stream, FIFO head
//   peakCount/peakStep : largest count this run and its first step
//   extinct      : run ended on a zero count (sticky)
//   overflow     : a record was dropped on a full FIFO (sticky)
//   busy         : run in progress
module infection_monitor
  import disease_pkg::*;
#(
  parameter int unsigned NUM_AGENTS = 10,
  parameter int unsigned SAMPLE_DIV = 1,
  parameter int unsigned MAX_STEPS  = 1024,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STEP_W     = 16,
  localparam int unsigned CW        = count_width(NUM_AGENTS),
  localparam int unsigned REC_W     = record_width(STEP_W, NUM_AGENTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_AGENTS-1:0] agentStates,
  input  logic                  loadState,
  input  logic                  start,
  output logic [REC_W-1:0]      sampleData,
  output logic                  sampleValid,
  input  logic                  sampleReady,
  output logic [CW-1:0]         peakCount,
  output logic [STEP_W-1:0]     peakStep,
  output logic                  extinct,
  output logic                  overflow,
  output logic                  busy
);
  localparam int unsigned       DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

  mon_state_e        state_q;
  logic              busy_q, extinct_q, overflow_q, rec_vld_q;
  logic [DIV_W-1:0]  div_q;
  logic [STEP_W-1:0] step_q, rec_step_q, peak_step_q;
  logic [CW-1:0]     rec_cnt_q, peak_q, pop_cnt_d;
  logic              tick, fifo_full, fifo_empty, fifo_pop, push_drop;

  always_comb begin
    pop_cnt_d = '0;
    for (int unsigned i = 0; i < NUM_AGENTS; i++) begin
      pop_cnt_d = pop_cnt_d + CW'(agentStates[i] == INF);
    end
  end

  assign tick      = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign fifo_pop  = !fifo_empty && sampleReady;
  assign push_drop = rec_vld_q && fifo_full && !fifo_pop;

  // The record captured on a tick edge is pushed on the following edge, so a
  // run that ends on its tick still delivers its last record from DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      div_q       <= '0;
      step_q      <= '0;
      rec_vld_q   <= 1'b0;
      rec_step_q  <= '0;
      rec_cnt_q   <= '0;
      peak_q      <= '0;
      peak_step_q <= '0;
      extinct_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (loadState) begin
      // Abort: pending record discarded, peak and sticky flags kept for readout.
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      rec_vld_q <= 1'b0;
      div_q     <= '0;
      step_q    <= '0;
    end else begin
      rec_vld_q <= 1'b0;
      if (push_drop) overflow_q <= 1'b1;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            div_q       <= '0;
            step_q      <= '0;
            peak_q      <= '0;
            peak_step_q <= '0;
            extinct_q   <= 1'b0;
            overflow_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (tick) begin
            div_q      <= '0;
            rec_vld_q  <= 1'b1;
            rec_cnt_q  <= pop_cnt_d;
            rec_step_q <= step_q;
            step_q     <= step_q + STEP_W'(1);
            if (pop_cnt_d > peak_q) begin
              peak_q      <= pop_cnt_d;
              peak_step_q <= step_q;
            end
            if (pop_cnt_d == '0 || step_q == STEP_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              if (pop_cnt_d == '0) extinct_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (loadState),
    .push_i  (rec_vld_q),
    .wdata_i ({rec_step_q, rec_cnt_q}),
    .pop_i   (fifo_pop),
    .rdata_o (sampleData),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign sampleValid = !fifo_empty;
  assign peakCount   = peak_q;
  assign peakStep    = peak_step_q;
  assign extinct     = extinct_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_infection_monitor.sv
// Bench for infection_monitor: a SAMPLE_DIV=1 instance checked every cycle against
// a transaction-level model (expected-record queue with capacity), plus a
// SAMPLE_DIV=4 instance checked by directed record collection.
module tb_infection_monitor;
  import disease_pkg::*;

  localparam int unsigned N     = 10;
  localparam int unsigned CW    = 4;
  localparam int unsigned SW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned MAXS  = 1024;
  localparam int unsigned RW    = $bits(record_t);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]  st1, st4;
  logic          ld1, go1, rdy1, ld4, go4, rdy4;
  logic [RW-1:0] data1, data4;
  logic          v1, v4, ex1, ex4, ov1, ov4, bz1, bz4;
  logic [CW-1:0] pk1, pk4;
  logic [SW-1:0] ps1, ps4;

  infection_monitor #(.NUM_AGENTS(N), .SAMPLE_DIV(1), .MAX_STEPS(MAXS),
                      .FIFO_DEPTH(DEPTH), .STEP_W(SW)) dut1 (
    .clk(clk), .rst(rst), .agentStates(st1), .loadState(ld1), .start(go1),
    .sampleData(data1), .sampleValid(v1), .sampleReady(rdy1),
    .peakCount(pk1), .peakStep(ps1), .extinct(ex1), .overflow(ov1), .busy(bz1));

  infection_monitor #(.NUM_AGENTS(N), .SAMPLE_DIV(4), .MAX_STEPS(MAXS),
                      .FIFO_DEPTH(DEPTH), .STEP_W(SW)) dut4 (
    .clk(clk), .rst(rst), .agentStates(st4), .loadState(ld4), .start(go4),
    .sampleData(data4), .sampleValid(v4), .sampleReady(rdy4),
    .peakCount(pk4), .peakStep(ps4), .extinct(ex4), .overflow(ov4), .busy(bz4));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops1  = 0;

  // Reference model for dut1.
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] m_pend;
  bit            m_run, m_pend_vld, m_ext, m_ovf;
  int            m_step, m_peak, m_peakstep;

  typedef struct {
    logic [RW-1:0] data;
    int            at;
  } got_t;
  got_t got4[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rand_nonzero();
    logic [N-1:0] s;
    s = N'($urandom);
    if (s == '0) s = N'(1);
    return s;
  endfunction

  // One clock: compare dut1 with the model at negedge, then advance the model
  // across the coming posedge using the inputs currently applied.
  task automatic cycle();
    int c;
    @(negedge clk);
    cyc++;
    chk("valid", 32'(v1), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("data", 32'(data1), 32'(exp_q[0]));
    chk("busy", 32'(bz1), 32'(m_run));
    chk("peakCount", 32'(pk1), 32'(m_peak));
    chk("peakStep", 32'(ps1), 32'(m_peakstep));
    chk("extinct", 32'(ex1), 32'(m_ext));
    chk("overflow", 32'(ov1), 32'(m_ovf));
    if (v4 && rdy4) got4.push_back('{data4, cyc});

    if (rst) begin
      exp_q.delete();
      m_run = 0; m_pend_vld = 0; m_ext = 0; m_ovf = 0;
      m_step = 0; m_peak = 0; m_peakstep = 0;
    end else if (ld1) begin
      exp_q.delete();
      m_pend_vld = 0;
      m_run = 0;
    end else begin
      if (exp_q.size() != 0 && rdy1) begin
        void'(exp_q.pop_front());
        pops1++;
      end
      if (m_pend_vld) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_pend);
        else m_ovf = 1;
      end
      m_pend_vld = 0;
      if (m_run) begin
        c = $countones(st1);
        m_pend = {m_step[SW-1:0], c[CW-1:0]};
        m_pend_vld = 1;
        if (c > m_peak) begin
          m_peak = c;
          m_peakstep = m_step;
        end
        if (c == 0) begin
          m_ext = 1;
          m_run = 0;
        end else if (m_step == MAXS - 1) begin
          m_run = 0;
        end
        m_step++;
      end else if (go1) begin
        m_run = 1; m_step = 0; m_peak = 0; m_peakstep = 0; m_ext = 0; m_ovf = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [RW-1:0] d0;
    logic [N-1:0]  pats [4];
    int            p0, exp_pk, exp_ps;

    rst = 1'b1;
    st1 = '0; ld1 = 1'b0; go1 = 1'b0; rdy1 = 1'b1;
    st4 = '0; ld4 = 1'b0; go4 = 1'b0; rdy4 = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) cycle();

    // Reset state
    chk("rst_data", 32'(data1), 0);
    chk("rst_valid", 32'(v1), 0);
    chk("rst_busy", 32'(bz1), 0);
    chk("rst_peak", 32'(pk1), 0);
    chk("rst_flags", 32'({ex1, ov1}), 0);
    chk("rst_dut4", 32'({v4, bz4, ex4, ov4, pk4}), 0);
    rst = 1'b0;
    cycle();

    // 1: all infected, first record two cycles after the first RUN cycle
    st1 = 10'h3FF; go1 = 1'b1;
    cycle();
    go1 = 1'b0;
    chk("t1_busy", 32'(bz1), 1);
    chk("t1_nvalid", 32'(v1), 0);
    cycle();
    chk("t1_nvalid2", 32'(v1), 0);
    cycle();
    chk("t1_first_valid", 32'(v1), 1);
    chk("t1_first_rec", 32'(data1), 32'({16'd0, 4'd10}));
    repeat (6) cycle();
    chk("t1_peak", 32'(pk1), 10);
    chk("t1_peak_step", 32'(ps1), 0);
    // random load with a lossy consumer through to the MAX_STEPS boundary
    for (int k = 0; k < 1030; k++) begin
      st1 = rand_nonzero();
      rdy1 = ($urandom_range(0, 3) != 0);
      cycle();
    end
    chk("t1_run_done", 32'(bz1), 0);
    chk("t1_not_extinct", 32'(ex1), 0);
    rdy1 = 1'b1;
    repeat (24) cycle();
    chk("t1_drained", 32'(v1), 0);

    // 2: extinction after three ticks
    p0 = pops1;
    st1 = 10'h007; go1 = 1'b1;
    cycle();
    go1 = 1'b0;
    repeat (3) cycle();
    st1 = '0;
    cycle();
    for (int k = 0; k < 8; k++) begin
      st1 = rand_nonzero();
      cycle();
    end
    chk("t2_extinct", 32'(ex1), 1);
    chk("t2_busy", 32'(bz1), 0);
    chk("t2_records", 32'(pops1 - p0), 4);
    chk("t2_peak", 32'({pk1, ps1}), 32'({4'd3, 16'd0}));

    // 3: stalled consumer, 20 ticks into a 16-deep FIFO
    rdy1 = 1'b0; go1 = 1'b1;
    cycle();
    go1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      st1 = rand_nonzero();
      cycle();
    end
    st1 = '0;
    cycle();
    cycle();
    d0 = data1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_hold", 32'(data1), 32'(d0));
    end
    chk("t3_overflow", 32'(ov1), 1);
    chk("t3_head_step0", 32'(data1[RW-1:CW]), 0);
    p0 = pops1;
    rdy1 = 1'b1;
    repeat (20) cycle();
    chk("t3_drained", 32'(pops1 - p0), 16);

    // 5: abort with records queued, flags retained, restart clears them
    rdy1 = 1'b0; go1 = 1'b1;
    cycle();
    go1 = 1'b0;
    for (int k = 0; k < 19; k++) begin
      st1 = rand_nonzero();
      cycle();
    end
    ld1 = 1'b1;
    cycle();
    ld1 = 1'b0;
    chk("t5_valid", 32'(v1), 0);
    chk("t5_busy", 32'(bz1), 0);
    chk("t5_ovf_kept", 32'(ov1), 1);
    repeat (2) cycle();
    rdy1 = 1'b1; go1 = 1'b1; st1 = rand_nonzero();
    cycle();
    go1 = 1'b0;
    chk("t5_flags_clr", 32'({ex1, ov1}), 0);
    cycle();
    cycle();
    chk("t5_restart_step", 32'(data1[RW-1:CW]), 0);
    for (int k = 0; k < 6; k++) begin
      st1 = rand_nonzero();
      cycle();
    end

    // 6: reset mid-run, then start together with loadState
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_rst_outs", 32'({v1, bz1, ex1, ov1, pk1}), 0);
    chk("t6_rst_step", 32'(ps1), 0);
    chk("t6_rst_data", 32'(data1), 0);
    go1 = 1'b1; ld1 = 1'b1;
    cycle();
    go1 = 1'b0; ld1 = 1'b0;
    cycle();
    chk("t6_stay_idle", 32'({bz1, v1}), 0);

    // 4: SAMPLE_DIV=4, one record per four cycles
    pats[0] = 10'h003; pats[1] = 10'h01F; pats[2] = 10'h3E0; pats[3] = 10'h200;
    got4.delete();
    go4 = 1'b1;
    cycle();
    go4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      st4 = pats[k];
      repeat (4) cycle();
    end
    st4 = '0;
    repeat (4) cycle();
    repeat (6) cycle();
    chk("t4_records", 32'(got4.size()), 5);
    exp_pk = 0;
    exp_ps = 0;
    for (int k = 0; k < 4; k++) begin
      if ($countones(pats[k]) > exp_pk) begin
        exp_pk = $countones(pats[k]);
        exp_ps = k;
      end
      if (k < got4.size()) begin
        chk("t4_rec", 32'(got4[k].data), (k << CW) | $countones(pats[k]));
        if (k + 1 < got4.size()) chk("t4_spacing", 32'(got4[k+1].at - got4[k].at), 4);
      end
    end
    if (got4.size() > 4) chk("t4_last_rec", 32'(got4[4].data), 32'(4 << CW));
    chk("t4_peak", 32'(pk4), 32'(exp_pk));
    chk("t4_peak_step", 32'(ps4), 32'(exp_ps));
    chk("t4_extinct", 32'({ex4, bz4}), 32'(2'b10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
